// File: rtl/ad9833_pkg.sv
// ad9833_pkg: AD9833 control-word constants and sequencer state type
package ad9833_pkg;
  localparam logic [15:0] B28 = 16'h2000;
  localparam logic [15:0] RESET = 16'h0100;
  localparam logic [15:0] FREQ0 = 16'h4000;
  localparam logic [15:0] PHASE0 = 16'hC000;
  localparam logic [2:0] NUM_WORDS = 3'd5;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, NEXT, DONE} state_t;
endpackage

// File: rtl/ad9833_spi_shifter.sv
// ad9833_spi_shifter: one 16-bit AD9833 frame, SCLK high in the first half of each bit
module ad9833_spi_shifter #(
  parameter int SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data,
  output logic        sclk,
  output logic        fsync,
  output logic        sdata,
  output logic        busy
);
  localparam int TW = $clog2(16 * SCLK_DIV + 5);
  localparam int PW = $clog2(SCLK_DIV);
  localparam logic [TW-1:0] T_BITS = TW'(16 * SCLK_DIV);
  localparam logic [TW-1:0] T_FS = TW'(16 * SCLK_DIV + 2);
  localparam logic [TW-1:0] T_END = TW'(16 * SCLK_DIV + 4);
  localparam logic [PW-1:0] P_LAST = PW'(SCLK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(SCLK_DIV / 2);
  logic [TW-1:0] t, tn;
  logic [PW-1:0] ph, phn;
  logic [15:0] sh;
  logic wrap;
  always_comb begin
    tn = t + 1'b1;
    wrap = ph == P_LAST;
    phn = wrap ? '0 : ph + 1'b1;
  end
  // outputs are registered for offset tn; the last bit is held until FSYNC rises
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      sclk <= 1'b1;
      fsync <= 1'b1;
      sdata <= 1'b0;
      t <= '0;
      ph <= '0;
      sh <= '0;
    end else if (!busy) begin
      if (start) begin
        busy <= 1'b1;
        sclk <= 1'b1;
        fsync <= 1'b0;
        sdata <= data[15];
        t <= '0;
        ph <= '0;
        sh <= data;
      end
    end else begin
      t <= tn;
      ph <= phn;
      if (wrap) sh <= {sh[14:0], 1'b0};
      sclk <= tn >= T_BITS || phn < P_HALF;
      sdata <= tn < T_BITS ? (wrap ? sh[14] : sh[15]) : (tn >= T_FS ? 1'b0 : sdata);
      fsync <= tn >= T_FS;
      busy <= tn != T_END;
    end
  end
endmodule

// File: rtl/ad9833_cfg_core.sv
// ad9833_cfg_core: sends the five-word AD9833 start-up sequence on request
module ad9833_cfg_core
  import ad9833_pkg::*;
#(
  parameter logic [27:0] FREQ_WORD = 28'd32212,
  parameter logic [11:0] PHASE_WORD = 12'd0,
  parameter int SCLK_DIV = 4
) (
  input  logic sys_clk_i,
  input  logic rst_i,
  input  logic start_cfg_pulse_i,
  output logic SCLK,
  output logic FSYNC,
  output logic SDATA,
  output logic cfg_busy_o,
  output logic cfg_done_o
);
  state_t state, nxt;
  logic [2:0] idx, idx_n;
  logic [15:0] word;
  logic sh_start, sh_busy;
  always_comb
    word = idx == 3'd0 ? B28 | RESET :
           idx == 3'd1 ? FREQ0 | {2'b0, FREQ_WORD[13:0]} :
           idx == 3'd2 ? FREQ0 | {2'b0, FREQ_WORD[27:14]} :
           idx == 3'd3 ? PHASE0 | {4'b0, PHASE_WORD} : B28;
  always_comb begin
    nxt = state;
    idx_n = idx;
    sh_start = 1'b0;
    case (state)
      IDLE: if (start_cfg_pulse_i) begin
        nxt = LOAD;
        idx_n = 3'd0;
      end
      LOAD: begin
        sh_start = 1'b1;
        nxt = WAIT_BUSY;
      end
      WAIT_BUSY: nxt = sh_busy ? WAIT_BUSY : NEXT;
      NEXT: begin
        idx_n = idx + 3'd1;
        nxt = idx_n < NUM_WORDS ? LOAD : DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx <= 3'd0;
    end else begin
      state <= nxt;
      idx <= idx_n;
    end
  end
  assign cfg_busy_o = state inside {LOAD, WAIT_BUSY, NEXT};
  assign cfg_done_o = state == DONE;
  ad9833_spi_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
    .clk(sys_clk_i),
    .rst(rst_i),
    .start(sh_start),
    .data(word),
    .sclk(SCLK),
    .fsync(FSYNC),
    .sdata(SDATA),
    .busy(sh_busy)
  );
endmodule

// File: tb/tb_ad9833_cfg_core.sv
// tb_ad9833_cfg_core: randomized scenario bench with a frame-level reference model
module tb_ad9833_cfg_core;
  localparam logic [27:0] F1 = 28'd32212;
  localparam logic [27:0] F2 = 28'h0FFFFFF;
  localparam logic [11:0] P = 12'd0;
  localparam int DIV = 4;
  localparam int LOW = 16 * DIV + 2;
  localparam int SEQ_MAX = 5 * (16 * DIV + 4 + 3) + 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
  logic sclk, fsync, sdata, busy, done;
  logic sclk2, fsync2, sdata2, busy2, done2;
  int total = 0, bad = 0;
  typedef struct {
    logic [15:0] w;
    int nbits;
    int low;
    int fmin;
    int fmax;
    int hi;
  } frame_t;
  frame_t fq[$];
  frame_t cur;
  logic [15:0] wq2[$];
  logic [15:0] cur2;
  int done_cnt = 0, done2_cnt = 0;
  always #5 clk = ~clk;
  ad9833_cfg_core #(.FREQ_WORD(F1), .PHASE_WORD(P), .SCLK_DIV(DIV)) dut (
    .sys_clk_i(clk), .rst_i(rst), .start_cfg_pulse_i(start),
    .SCLK(sclk), .FSYNC(fsync), .SDATA(sdata), .cfg_busy_o(busy), .cfg_done_o(done)
  );
  ad9833_cfg_core #(.FREQ_WORD(F2), .PHASE_WORD(P), .SCLK_DIV(DIV)) dut2 (
    .sys_clk_i(clk), .rst_i(rst), .start_cfg_pulse_i(start2),
    .SCLK(sclk2), .FSYNC(fsync2), .SDATA(sdata2), .cfg_busy_o(busy2), .cfg_done_o(done2)
  );
  function automatic logic [15:0] exp_word(input int i, input logic [27:0] f, input logic [11:0] p);
    case (i)
      0: return 16'h2100;
      1: return 16'h4000 + 16'(f % 28'd16384);
      2: return 16'h4000 + 16'(f / 28'd16384);
      3: return 16'hC000 + 16'(p);
      default: return 16'h2000;
    endcase
  endfunction
  // bus observer: records each frame as seen on the pins, sampled mid-cycle
  initial begin
    logic ps = 1'b1, pf = 1'b1, ps2 = 1'b1, pf2 = 1'b1;
    int cyc = 0, hi_cnt = 0, last_fall = -1, gap;
    cur2 = '0;
    cur = '{w: '0, nbits: 0, low: 0, fmin: 1 << 30, fmax: 0, hi: 0};
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (done2) done2_cnt++;
      if (!fsync && pf) begin
        cur = '{w: '0, nbits: 0, low: 0, fmin: 1 << 30, fmax: 0, hi: hi_cnt};
        last_fall = -1;
      end
      if (!fsync) begin
        cur.low++;
        if (ps && !sclk) begin
          cur.w = {cur.w[14:0], sdata};
          cur.nbits++;
          if (last_fall >= 0) begin
            gap = cyc - last_fall;
            if (gap < cur.fmin) cur.fmin = gap;
            if (gap > cur.fmax) cur.fmax = gap;
          end
          last_fall = cyc;
        end
      end
      if (fsync && !pf) begin
        fq.push_back(cur);
        hi_cnt = 0;
      end
      if (fsync) hi_cnt++;
      ps = sclk;
      pf = fsync;
      if (!fsync2 && pf2) cur2 = '0;
      if (!fsync2 && ps2 && !sclk2) cur2 = {cur2[14:0], sdata2};
      if (fsync2 && !pf2) wq2.push_back(cur2);
      ps2 = sclk2;
      pf2 = fsync2;
    end
  end
  task automatic check_idle(input string tag);
    total++;
    if (sclk !== 1'b1) begin bad++; $display("FAIL %s_sclk got=%b want=1", tag, sclk); end
    total++;
    if (fsync !== 1'b1) begin bad++; $display("FAIL %s_fsync got=%b want=1", tag, fsync); end
    total++;
    if (sdata !== 1'b0) begin bad++; $display("FAIL %s_sdata got=%b want=0", tag, sdata); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b want=0", tag, busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL %s_done got=%b want=0", tag, done); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_idle("reset_start_ignored");
    total++;
    if (fq.size() !== 0) begin bad++; $display("FAIL reset_frames got=%0d want=0", fq.size()); end
  endtask
  task automatic test_sequence(input bit extra);
    int n0, d0, n, r;
    bit seen;
    n0 = fq.size();
    d0 = done_cnt;
    r = $urandom_range(30, 340);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL seq_busy_rise got=%b want=1", busy); end
    n = 1;
    seen = 1'b0;
    while (!seen && n < SEQ_MAX + 20) begin
      start = extra && (n == 20 || n == r);
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1'b1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL seq_busy_in_done got=%b want=0", busy); end
      end
    end
    start = 1'b0;
    total++;
    if (!seen || n > SEQ_MAX) begin bad++; $display("FAIL seq_duration got=%0d want<=%0d", n, SEQ_MAX); end
    repeat (5) @(negedge clk);
    check_idle("seq_end");
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL seq_done_pulses got=%0d want=1", done_cnt - d0); end
    total++;
    if (fq.size() - n0 !== 5) begin bad++; $display("FAIL seq_frames got=%0d want=5", fq.size() - n0); end
    for (int i = 0; i < 5 && n0 + i < fq.size(); i++) begin
      total++;
      if (fq[n0+i].w !== exp_word(i, F1, P))
        begin bad++; $display("FAIL seq_word%0d got=%h want=%h", i, fq[n0+i].w, exp_word(i, F1, P)); end
      total++;
      if (fq[n0+i].nbits !== 16) begin bad++; $display("FAIL seq_bits%0d got=%0d want=16", i, fq[n0+i].nbits); end
      total++;
      if (fq[n0+i].low !== LOW) begin bad++; $display("FAIL seq_fsync_low%0d got=%0d want=%0d", i, fq[n0+i].low, LOW); end
      total++;
      if (fq[n0+i].fmin !== DIV || fq[n0+i].fmax !== DIV)
        begin bad++; $display("FAIL seq_fall_gap%0d got=%0d..%0d want=%0d", i, fq[n0+i].fmin, fq[n0+i].fmax, DIV); end
      if (i > 0) begin
        total++;
        if (fq[n0+i].hi < 2) begin bad++; $display("FAIL seq_fsync_gap%0d got=%0d want>=2", i, fq[n0+i].hi); end
      end
    end
  endtask
  task automatic test_abort;
    int n0, n, r, nb;
    n0 = fq.size();
    r = $urandom_range(0, DIV - 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (fq.size() < n0 + 2 && n < 3 * SEQ_MAX) begin @(negedge clk); n++; end
    n = 0;
    while (fsync && n < 20) begin @(negedge clk); n++; end
    total++;
    if (fsync !== 1'b0) begin bad++; $display("FAIL abort_frame3_start got=%b want=0", fsync); end
    repeat (DIV * 7 + r) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort");
    rst = 1'b0;
    nb = 0;
    for (int k = 0; k < 16; k++) if (DIV * k + DIV / 2 <= DIV * 7 + r) nb++;
    repeat (500) @(negedge clk);
    check_idle("abort_quiet");
    total++;
    if (fq.size() - n0 !== 3) begin bad++; $display("FAIL abort_frames got=%0d want=3", fq.size() - n0); end
    if (fq.size() > n0 + 2) begin
      total++;
      if (fq[n0+2].nbits !== nb) begin bad++; $display("FAIL abort_bits got=%0d want=%0d", fq[n0+2].nbits, nb); end
    end
  endtask
  task automatic test_freq;
    int n0, d0, n;
    n0 = wq2.size();
    d0 = done2_cnt;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (done2_cnt == d0 && n < SEQ_MAX + 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    total++;
    if (done2_cnt - d0 !== 1) begin bad++; $display("FAIL freq_done got=%0d want=1", done2_cnt - d0); end
    total++;
    if (wq2.size() - n0 !== 5) begin bad++; $display("FAIL freq_frames got=%0d want=5", wq2.size() - n0); end
    for (int i = 0; i < 5 && n0 + i < wq2.size(); i++) begin
      total++;
      if (wq2[n0+i] !== exp_word(i, F2, P))
        begin bad++; $display("FAIL freq_word%0d got=%h want=%h", i, wq2[n0+i], exp_word(i, F2, P)); end
    end
  endtask
  initial begin
    test_reset;
    test_sequence(1'b1);
    repeat (10000) @(negedge clk);
    test_sequence(1'b0);
    test_abort;
    test_sequence(1'b1);
    test_freq;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
